obq_branch_queue: RTL and testbench

- Ordered Branch Queue (OBQ): circular FIFO with one entry per in-flight predicted conditional branch, in program order.
- Entry contents: GSHARE global-history snapshot taken before the branch's own history update, fetch PC, and predicted direction.
- On a mispredict it returns the snapshot and PC to GSHARE, which restores history and trains the PHT. It also squashes all younger entries.
- Sits between fetch/GSHARE (writer) and branch resolution/retire (consumers).

---
 rtl/obq_branch_queue_pkg.sv | 30 +++
 rtl/obq_branch_queue_if.sv | 40 ++++
 rtl/obq_branch_queue_ptr.sv | 35 +++
 rtl/obq_branch_queue.sv | 127 ++++++++++++
 tb/tb_obq_branch_queue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/obq_branch_queue_pkg.sv
// Shared types and sizing for the ordered branch queue.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
`ifndef BH_SIZE
`define BH_SIZE 8
`endif

package obq_branch_queue_pkg;

    localparam int OBQ_DEPTH = 16;
    localparam int TAG_W     = $clog2(OBQ_DEPTH);
    localparam int BH_SIZE   = `BH_SIZE;

    typedef logic [TAG_W-1:0] obq_tag_t;
    // Pointer is the index plus one wrap bit, so full and empty can be told apart.
    typedef logic [TAG_W:0]   obq_ptr_t;

    typedef struct packed {
        logic [BH_SIZE-1:0] bh;
        logic [31:0]        pc;
        logic               pred;
        logic               valid;
    } obq_entry_t;

    // Age of a slot relative to the head (0 = oldest). Wraps modulo OBQ_DEPTH.
    function automatic obq_tag_t obq_age(input obq_tag_t tag, input obq_tag_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/obq_branch_queue_if.sv
// Bundle of the queue's allocate / retire / mispredict / rollback signals.
// Latency: n/a (wiring only).
// Backpressure: writer sees write_ack; slave drives status and rollback outputs.
interface obq_branch_queue_if;
    import obq_branch_queue_pkg::*;

    // allocation (from fetch / GSHARE)
    logic               write_en;
    logic [BH_SIZE-1:0] bh_in;
    logic [31:0]        pc_in;
    logic               pred_in;
    obq_tag_t           write_tag;
    logic               write_ack;

    // resolution / retire
    logic               retire_en;
    logic               mispredict_en;
    obq_tag_t           mispredict_tag;

    // rollback back to GSHARE
    logic               rollback_valid;
    logic [BH_SIZE-1:0] rollback_gh;
    logic [31:0]        rollback_pc;

    // occupancy
    logic               full;
    logic               empty;
    obq_ptr_t           count;

    modport master (
        output write_en, bh_in, pc_in, pred_in, retire_en, mispredict_en, mispredict_tag,
        input  write_tag, write_ack, rollback_valid, rollback_gh, rollback_pc, full, empty, count
    );

    modport slave (
        input  write_en, bh_in, pc_in, pred_in, retire_en, mispredict_en, mispredict_tag,
        output write_tag, write_ack, rollback_valid, rollback_gh, rollback_pc, full, empty, count
    );

endinterface

// File: rtl/obq_branch_queue_ptr.sv
// Circular pointer (index + wrap bit) with increment and parallel load; load wins.
// Latency: 1 cycle from inc/load to ptr_q.
// Backpressure: none; caller gates inc/load.
module obq_branch_queue_ptr
    import obq_branch_queue_pkg::*;
(
    input  logic     clock,
    input  logic     reset,     // async, active-low
    input  logic     inc,
    input  logic     load,
    input  obq_ptr_t load_val,
    output obq_ptr_t ptr_q
);

    obq_ptr_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            // Natural overflow of the index carries into the wrap bit.
            ptr_d = ptr_q + obq_ptr_t'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/obq_branch_queue.sv
// Ordered branch queue: program-order FIFO of {history snapshot, PC, prediction}; squash + rollback on mispredict.
// Latency: write_ack combinational; rollback_* registered, 1 cycle after an honoured mispredict.
// Backpressure: writes refused when full (pre-cycle state) or when a mispredict is presented.
module obq_branch_queue
    import obq_branch_queue_pkg::*;
(
    input  logic clock,
    input  logic reset,          // async, active-low
    obq_branch_queue_if.slave bus
);

    obq_entry_t         entries_q [OBQ_DEPTH];
    obq_entry_t         entries_d [OBQ_DEPTH];

    obq_ptr_t           head_q;
    obq_ptr_t           tail_q;
    obq_ptr_t           tail_load_val;

    logic               rollback_valid_q, rollback_valid_d;
    logic [BH_SIZE-1:0] rollback_gh_q,    rollback_gh_d;
    logic [31:0]        rollback_pc_q,    rollback_pc_d;

    obq_tag_t           head_idx;
    obq_tag_t           tail_idx;
    obq_tag_t           mp_age;
    obq_ptr_t           count_w;
    logic               full_w;
    logic               empty_w;
    logic               write_go;
    logic               retire_go;
    logic               mp_go;

    assign head_idx  = head_q[TAG_W-1:0];
    assign tail_idx  = tail_q[TAG_W-1:0];
    assign count_w   = tail_q - head_q;
    assign full_w    = (count_w == obq_ptr_t'(OBQ_DEPTH));
    assign empty_w   = (count_w == '0);

    assign write_go  = bus.write_en & ~full_w & ~bus.mispredict_en;
    assign retire_go = bus.retire_en & ~empty_w;
    // Only a live slot may roll back; a stale tag is silently dropped.
    assign mp_go     = bus.mispredict_en & entries_q[bus.mispredict_tag].valid;
    assign mp_age    = obq_age(bus.mispredict_tag, head_idx);

    // New tail sits just past the mispredicted entry. Building it from the
    // pre-cycle head gives the correct wrap bit even when the tag index is
    // numerically below the head index.
    assign tail_load_val = head_q + obq_ptr_t'({1'b0, mp_age}) + obq_ptr_t'(1);

    obq_branch_queue_ptr u_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (retire_go),
        .load     (1'b0),
        .load_val ('0),
        .ptr_q    (head_q)
    );

    obq_branch_queue_ptr u_tail (
        .clock    (clock),
        .reset    (reset),
        .inc      (write_go),
        .load     (mp_go),
        .load_val (tail_load_val),
        .ptr_q    (tail_q)
    );

    always_comb begin
        entries_d = entries_q;

        if (retire_go) begin
            entries_d[head_idx].valid = 1'b0;
        end

        // Squash everything strictly younger than the mispredicted branch.
        if (mp_go) begin
            for (int i = 0; i < OBQ_DEPTH; i++) begin
                if (obq_age(obq_tag_t'(i), head_idx) > mp_age) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end

        // Never coincides with a squash: a mispredict blocks the write.
        if (write_go) begin
            entries_d[tail_idx] = '{bh: bus.bh_in, pc: bus.pc_in, pred: bus.pred_in, valid: 1'b1};
        end
    end

    always_comb begin
        rollback_valid_d = mp_go;
        rollback_gh_d    = rollback_gh_q;
        rollback_pc_d    = rollback_pc_q;
        if (mp_go) begin
            rollback_gh_d = entries_q[bus.mispredict_tag].bh;
            rollback_pc_d = entries_q[bus.mispredict_tag].pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OBQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rollback_valid_q <= 1'b0;
            rollback_gh_q    <= '0;
            rollback_pc_q    <= '0;
        end else begin
            for (int i = 0; i < OBQ_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            rollback_valid_q <= rollback_valid_d;
            rollback_gh_q    <= rollback_gh_d;
            rollback_pc_q    <= rollback_pc_d;
        end
    end

    assign bus.write_tag      = tail_idx;
    assign bus.write_ack      = write_go;
    assign bus.full           = full_w;
    assign bus.empty          = empty_w;
    assign bus.count          = count_w;
    assign bus.rollback_valid = rollback_valid_q;
    assign bus.rollback_gh    = rollback_gh_q;
    assign bus.rollback_pc    = rollback_pc_q;

endmodule

// File: tb/tb_obq_branch_queue.sv
// Testbench for obq_branch_queue: queue-based reference model, directed cases plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_obq_branch_queue;
    import obq_branch_queue_pkg::*;

    logic clock;
    logic reset;

    obq_branch_queue_if bus();

    obq_branch_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: live entries in program order, plus the head tag.
    typedef struct {
        logic [BH_SIZE-1:0] bh;
        logic [31:0]        pc;
        int                 tag;
    } ment_t;

    ment_t              mq[$];
    int                 m_head   = 0;
    logic               m_rb_vld = 1'b0;
    logic [BH_SIZE-1:0] m_rb_gh  = '0;
    logic [31:0]        m_rb_pc  = '0;

    // Outputs sampled during the last cycle, for literal checks.
    logic [63:0] obs_tag, obs_ack, obs_full, obs_empty, obs_count, obs_rb_vld, obs_rb_gh, obs_rb_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head   = 0;
        m_rb_vld = 1'b0;
        m_rb_gh  = '0;
        m_rb_pc  = '0;
    endtask

    // One clock cycle: drive, compare against model, then advance the model.
    task automatic cyc(input logic we, input logic [BH_SIZE-1:0] bh, input logic [31:0] pc,
                       input logic pred, input logic re, input logic me, input int mtag);
        int   size;
        int   e_tag;
        logic e_full, e_empty, e_ack;
        int   hit;

        @(negedge clock);
        bus.write_en       = we;
        bus.bh_in          = bh;
        bus.pc_in          = pc;
        bus.pred_in        = pred;
        bus.retire_en      = re;
        bus.mispredict_en  = me;
        bus.mispredict_tag = obq_tag_t'(mtag);
        #1;

        size    = mq.size();
        e_full  = (size == OBQ_DEPTH);
        e_empty = (size == 0);
        e_tag   = (m_head + size) % OBQ_DEPTH;
        e_ack   = we && !e_full && !me;

        obs_tag    = 64'(bus.write_tag);
        obs_ack    = 64'(bus.write_ack);
        obs_full   = 64'(bus.full);
        obs_empty  = 64'(bus.empty);
        obs_count  = 64'(bus.count);
        obs_rb_vld = 64'(bus.rollback_valid);
        obs_rb_gh  = 64'(bus.rollback_gh);
        obs_rb_pc  = 64'(bus.rollback_pc);

        check("write_tag", obs_tag,   64'(e_tag));
        check("write_ack", obs_ack,   64'(e_ack));
        check("full",      obs_full,  64'(e_full));
        check("empty",     obs_empty, 64'(e_empty));
        check("count",     obs_count, 64'(size));
        check("rollback_valid", obs_rb_vld, 64'(m_rb_vld));
        if (m_rb_vld) begin
            check("rollback_gh", obs_rb_gh, 64'(m_rb_gh));
            check("rollback_pc", obs_rb_pc, 64'(m_rb_pc));
        end

        @(posedge clock);

        hit = -1;
        if (me) begin
            for (int k = 0; k < size; k++) begin
                if (mq[k].tag == mtag) hit = k;
            end
        end
        m_rb_vld = (hit >= 0);
        if (hit >= 0) begin
            m_rb_gh = mq[hit].bh;
            m_rb_pc = mq[hit].pc;
            while (mq.size() > hit + 1) void'(mq.pop_back());
        end
        if (re && size > 0) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % OBQ_DEPTH;
        end
        if (e_ack) begin
            mq.push_back('{bh: bh, pc: pc, tag: e_tag});
        end
    endtask

    task automatic wr(input logic [BH_SIZE-1:0] bh, input logic [31:0] pc);
        cyc(1'b1, bh, pc, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic ret();
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic mp(input int tag);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    task automatic rnd_cycles(input int n);
        logic we, re, me;
        int   mtag;
        for (int c = 0; c < n; c++) begin
            we   = ($urandom_range(0, 3) != 0);
            re   = ($urandom_range(0, 9) < 4);
            me   = ($urandom_range(0, 9) == 0);
            mtag = $urandom_range(0, OBQ_DEPTH - 1);
            if (me && mq.size() > 0 && $urandom_range(0, 1) == 1)
                mtag = mq[$urandom_range(0, mq.size() - 1)].tag;
            cyc(we, BH_SIZE'($urandom), $urandom, 1'($urandom), re, me, mtag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        bus.write_en       = 1'b0;
        bus.bh_in          = '0;
        bus.pc_in          = '0;
        bus.pred_in        = 1'b0;
        bus.retire_en      = 1'b0;
        bus.mispredict_en  = 1'b0;
        bus.mispredict_tag = '0;
        model_reset();

        repeat (2) @(negedge clock);
        #1;
        check("rst_count",  64'(bus.count), 64'd0);
        check("rst_empty",  64'(bus.empty), 64'd1);
        check("rst_full",   64'(bus.full), 64'd0);
        check("rst_rb_vld", 64'(bus.rollback_valid), 64'd0);
        check("rst_rb_gh",  64'(bus.rollback_gh), 64'd0);
        check("rst_rb_pc",  64'(bus.rollback_pc), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Three allocations get consecutive tags.
        wr(8'h11, 32'h100); check("lit_tag0", obs_tag, 64'd0); check("lit_ack0", obs_ack, 64'd1);
        wr(8'h22, 32'h104); check("lit_tag1", obs_tag, 64'd1);
        wr(8'h33, 32'h108); check("lit_tag2", obs_tag, 64'd2);
        idle();             check("lit_count3", obs_count, 64'd3); check("lit_nonempty", obs_empty, 64'd0);

        // Mispredict tag 2 of 5: rollback data next cycle, two younger squashed.
        wr(8'h44, 32'h10C);
        wr(8'h55, 32'h110);
        mp(2);
        idle();
        check("lit_rb_vld", obs_rb_vld, 64'd1);
        check("lit_rb_gh",  obs_rb_gh, 64'h33);
        check("lit_rb_pc",  obs_rb_pc, 64'h108);
        check("lit_mp_count", obs_count, 64'd3);
        check("lit_mp_tag", obs_tag, 64'd3);
        idle();
        check("lit_rb_pulse", obs_rb_vld, 64'd0);
        repeat (3) ret();

        // Fill from head 3; tags 3..15,0..2 carry bh 0xA0+i, pc 0x200+4i.
        for (int i = 0; i < OBQ_DEPTH; i++) wr(BH_SIZE'(8'hA0 + i), 32'h200 + 32'(4 * i));
        wr(8'hEE, 32'hEEE);
        check("lit_full", obs_full, 64'd1);
        check("lit_full_ack", obs_ack, 64'd0);
        idle();
        check("lit_count16", obs_count, 64'd16);
        cyc(1'b1, 8'hEF, 32'hEEF, 1'b0, 1'b1, 1'b0, 0);
        check("lit_full_rw_ack", obs_ack, 64'd0);
        idle();
        check("lit_count15", obs_count, 64'd15);

        // Head to 14: live tags 14,15,0,1,2. Trim to 14,15,0,1 then squash at 15.
        repeat (10) ret();
        mp(1);
        mp(15);
        idle();
        check("lit_wrap_count", obs_count, 64'd2);
        check("lit_wrap_tag", obs_tag, 64'd0);
        check("lit_wrap_rb_gh", obs_rb_gh, 64'hAC);
        mp(0);
        idle();
        check("lit_stale_rb", obs_rb_vld, 64'd0);
        check("lit_stale_count", obs_count, 64'd2);
        check("lit_stale_tag", obs_tag, 64'd0);

        // Mispredict on the head with retire and write in the same cycle.
        cyc(1'b1, 8'h77, 32'h777, 1'b1, 1'b1, 1'b1, 14);
        check("lit_mphead_ack", obs_ack, 64'd0);
        idle();
        check("lit_mphead_empty", obs_empty, 64'd1);
        check("lit_mphead_rb", obs_rb_vld, 64'd1);
        check("lit_mphead_gh", obs_rb_gh, 64'hAB);
        check("lit_mphead_pc", obs_rb_pc, 64'h22C);

        rnd_cycles(3000);

        // Asynchronous reset mid-queue with a rollback pending.
        wr(8'h01, 32'h1000);
        wr(8'h02, 32'h1004);
        wr(8'h03, 32'h1008);
        mp(mq[mq.size() - 2].tag);
        #2;
        reset = 1'b0;
        #1;
        check("lit_arst_count", 64'(bus.count), 64'd0);
        check("lit_arst_empty", 64'(bus.empty), 64'd1);
        check("lit_arst_rb",    64'(bus.rollback_valid), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        rnd_cycles(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
